// File: rtl/warp_scheduler.sv
// ============================================================================
// Module   : warp_scheduler
// Purpose  : Per-core warp scheduler driving warp_select/core_state/current_pc
//            through the FETCH..UPDATE loop; optional WAIT-state warp switching
//            enabled by defining WARP_SWITCH_ON_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_scheduler #(
    parameter int NUM_WARPS         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    localparam int SEL_W            = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_WARPS-1:0]          warp_enable,
    input  logic [NUM_WARPS-1:0][7:0]     saved_pc,
    input  logic [NUM_WARPS-1:0][2:0]     saved_state,
    input  logic                          fetcher_done,
    input  logic [NUM_WARPS-1:0]          mem_pending,
    input  logic                          decoded_ret,
    input  logic [7:0]                    next_pc,
    output logic [SEL_W-1:0]              warp_select,
    output logic [2:0]                    core_state,
    output logic [7:0]                    current_pc,
    output logic                          done
);

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [7:0]             pc_q, pc_d;
    logic                   done_q, done_d;
    logic [NUM_WARPS-1:0]   live_q, live_d;
    logic [NUM_WARPS-1:0]   retired_q, retired_d;

    logic [NUM_WARPS-1:0]   w_retired_after;
    logic [NUM_WARPS-1:0]   w_unretired;
    logic [SEL_W-1:0]       w_nxt_idx;
    logic [SEL_W-1:0]       w_sw_idx;
    logic [SEL_W-1:0]       w_lowest;
    state_t                 w_sw_state;
    logic [7:0]             w_sw_pc;

    // Nearest requester after base, wrapping; base itself is never a requester.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_WARPS-1:0] req,
                                                 input logic [SEL_W-1:0]     base);
        logic [SEL_W-1:0] idx;
        rr_pick = base;
        for (int i = NUM_WARPS - 1; i >= 1; i--) begin
            idx = SEL_W'((int'(base) + i) % NUM_WARPS);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign w_retired_after = retired_q | (NUM_WARPS'(1) << sel_q);
    assign w_unretired     = live_q & ~w_retired_after;
    assign w_nxt_idx       = rr_pick(w_unretired, sel_q);

`ifdef WARP_SWITCH_ON_WAIT_EN
    logic [NUM_WARPS-1:0]   w_ready;
    logic [SEL_W-1:0]       w_rdy_idx;

    always_comb begin
        w_ready = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_ready[w] = live_q[w] && !retired_q[w] && (SEL_W'(w) != sel_q) &&
                         ((saved_state[w] != CORE_WAIT) || !mem_pending[w]);
        end
    end

    assign w_rdy_idx = rr_pick(w_ready, sel_q);
    assign w_sw_idx  = (state_q == CORE_UPDATE) ? w_nxt_idx : w_rdy_idx;
`else
    assign w_sw_idx  = w_nxt_idx;
`endif

    // A warp that has never run starts fresh rather than from its saved context.
    always_comb begin
        w_sw_state = state_t'(saved_state[w_sw_idx]);
        w_sw_pc    = saved_pc[w_sw_idx];
        if (saved_state[w_sw_idx] == CORE_IDLE) begin
            w_sw_state = CORE_FETCH;
            w_sw_pc    = 8'h00;
        end
    end

    always_comb begin
        w_lowest = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (warp_enable[i]) w_lowest = SEL_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        pc_d      = pc_q;
        done_d    = done_q;
        live_d    = live_q;
        retired_d = retired_q;
        case (state_q)
            CORE_IDLE: begin
                if (start) begin
                    live_d    = warp_enable;
                    retired_d = '0;
                    if (|warp_enable) begin
                        sel_d   = w_lowest;
                        pc_d    = 8'h00;
                        state_d = CORE_FETCH;
                    end else begin
                        state_d = CORE_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            CORE_FETCH:   if (fetcher_done) state_d = CORE_DECODE;
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            CORE_WAIT: begin
                if (!mem_pending[sel_q]) begin
                    state_d = CORE_EXECUTE;
                end
`ifdef WARP_SWITCH_ON_WAIT_EN
                else if (|w_ready) begin
                    sel_d   = w_sw_idx;
                    state_d = w_sw_state;
                    pc_d    = w_sw_pc;
                end
`endif
            end
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                if (decoded_ret) begin
                    retired_d = w_retired_after;
                    if (w_unretired == '0) begin
                        state_d = CORE_DONE;
                        done_d  = 1'b1;
                    end else begin
                        sel_d   = w_sw_idx;
                        state_d = w_sw_state;
                        pc_d    = w_sw_pc;
                    end
                end else begin
                    pc_d    = next_pc;
                    state_d = CORE_FETCH;
                end
            end
            CORE_DONE:    state_d = CORE_DONE;
            default:      state_d = CORE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CORE_IDLE;
            sel_q     <= '0;
            pc_q      <= 8'h00;
            done_q    <= 1'b0;
            live_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
            live_q    <= live_d;
            retired_q <= retired_d;
        end
    end

    assign warp_select = sel_q;
    assign core_state  = state_q;
    assign current_pc  = pc_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_warp_scheduler.sv
// ============================================================================
// Module   : tb_warp_scheduler
// Purpose  : Scoreboard bench for warp_scheduler (two warps).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_warp_scheduler;

    localparam logic [2:0] c_IDLE = 3'd0, c_FETCH = 3'd1, c_DECODE = 3'd2,
                           c_REQUEST = 3'd3, c_WAIT = 3'd4, c_EXECUTE = 3'd5,
                           c_UPDATE = 3'd6, c_DONE = 3'd7;

    typedef struct packed {
        logic [2:0] st;
        logic [0:0] sel;
        logic [7:0] pc;
        logic       dn;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset, start, fetcher_done, decoded_ret;
    logic [1:0]      warp_enable, mem_pending;
    logic [1:0][7:0] saved_pc;
    logic [1:0][2:0] saved_state;
    logic [7:0]      next_pc;
    logic [0:0]      warp_select;
    logic [2:0]      core_state;
    logic [7:0]      current_pc;
    logic            done;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    string tag_q[$];

    warp_scheduler #(.NUM_WARPS(2), .THREADS_PER_BLOCK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .warp_enable(warp_enable),
        .saved_pc(saved_pc), .saved_state(saved_state), .fetcher_done(fetcher_done),
        .mem_pending(mem_pending), .decoded_ret(decoded_ret), .next_pc(next_pc),
        .warp_select(warp_select), .core_state(core_state),
        .current_pc(current_pc), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expected post-edge outputs, advance one clock, then pop and compare.
    task automatic cyc(input string tag, input logic [2:0] st, input logic sel,
                       input logic [7:0] pc, input logic dn);
        exp_t  e;
        string t;
        sb_q.push_back('{st: st, sel: sel, pc: pc, dn: dn});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".state"}, 32'(core_state), 32'(e.st));
        check({t, ".sel"},   32'(warp_select), 32'(e.sel));
        check({t, ".pc"},    32'(current_pc), 32'(e.pc));
        check({t, ".done"},  32'(done), 32'(e.dn));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; fetcher_done = 1'b0; decoded_ret = 1'b0;
        warp_enable = 2'b00; mem_pending = 2'b00; next_pc = 8'h00;
        saved_pc = '0; saved_state = '0;

        // Single warp, immediate RET
        cyc("rst", c_IDLE, 0, 8'h00, 0);
        reset = 0; warp_enable = 2'b01; start = 1;
        cyc("s1_start", c_FETCH, 0, 8'h00, 0);
        start = 0;
        cyc("s1_fetch2", c_FETCH, 0, 8'h00, 0);
        cyc("s1_fetch3", c_FETCH, 0, 8'h00, 0);
        fetcher_done = 1;
        cyc("s1_dec", c_DECODE, 0, 8'h00, 0);
        fetcher_done = 0;
        cyc("s1_req", c_REQUEST, 0, 8'h00, 0);
        cyc("s1_wait", c_WAIT, 0, 8'h00, 0);
        cyc("s1_exe", c_EXECUTE, 0, 8'h00, 0);
        cyc("s1_upd", c_UPDATE, 0, 8'h00, 0);
        decoded_ret = 1;
        cyc("s1_done", c_DONE, 0, 8'h00, 1);
        decoded_ret = 0; start = 1;
        cyc("s1_hold", c_DONE, 0, 8'h00, 1);
        start = 0;

        // Two warps: latency hiding / priority / pc update / two RETs
        reset = 1;
        cyc("s2_rst", c_IDLE, 0, 8'h00, 0);
        reset = 0; warp_enable = 2'b11; saved_state = '0; saved_pc[1] = 8'h77; start = 1;
        cyc("s2_start", c_FETCH, 0, 8'h00, 0);
        start = 0; fetcher_done = 1;
        cyc("s2_dec", c_DECODE, 0, 8'h00, 0);
        fetcher_done = 0;
        cyc("s2_req", c_REQUEST, 0, 8'h00, 0);
        cyc("s2_wait", c_WAIT, 0, 8'h00, 0);
        mem_pending = 2'b01;
`ifdef WARP_SWITCH_ON_WAIT_EN
        cyc("s2_switch", c_FETCH, 1, 8'h00, 0);
        saved_state[0] = c_WAIT; saved_pc[0] = 8'h10; fetcher_done = 1;
        cyc("s2_w1dec", c_DECODE, 1, 8'h00, 0);
        fetcher_done = 0;
        cyc("s2_w1req", c_REQUEST, 1, 8'h00, 0);
        mem_pending = 2'b11;
        cyc("s2_w1wait", c_WAIT, 1, 8'h00, 0);
        cyc("s2_w1hold", c_WAIT, 1, 8'h00, 0);
        mem_pending = 2'b00;
        cyc("s2_prio", c_EXECUTE, 1, 8'h00, 0);
        cyc("s2_w1upd", c_UPDATE, 1, 8'h00, 0);
        decoded_ret = 1;
        cyc("s2_resume0", c_WAIT, 0, 8'h10, 0);
        decoded_ret = 0;
        cyc("s2_w0exe", c_EXECUTE, 0, 8'h10, 0);
        cyc("s2_w0upd", c_UPDATE, 0, 8'h10, 0);
        decoded_ret = 1;
        cyc("s2_done", c_DONE, 0, 8'h10, 1);
`else
        for (int i = 0; i < 10; i++) cyc("s2_hold", c_WAIT, 0, 8'h00, 0);
        mem_pending = 2'b00;
        cyc("s2_prio", c_EXECUTE, 0, 8'h00, 0);
        decoded_ret = 0; next_pc = 8'h2A;
        cyc("s2_upd", c_UPDATE, 0, 8'h00, 0);
        cyc("s2_pc", c_FETCH, 0, 8'h2A, 0);
        fetcher_done = 1;
        cyc("s2_dec2", c_DECODE, 0, 8'h2A, 0);
        fetcher_done = 0;
        cyc("s2_req2", c_REQUEST, 0, 8'h2A, 0);
        cyc("s2_wait2", c_WAIT, 0, 8'h2A, 0);
        cyc("s2_exe2", c_EXECUTE, 0, 8'h2A, 0);
        cyc("s2_upd2", c_UPDATE, 0, 8'h2A, 0);
        decoded_ret = 1;
        cyc("s2_ret0", c_FETCH, 1, 8'h00, 0);
        decoded_ret = 0; fetcher_done = 1;
        cyc("s2_w1dec", c_DECODE, 1, 8'h00, 0);
        fetcher_done = 0;
        cyc("s2_w1req", c_REQUEST, 1, 8'h00, 0);
        cyc("s2_w1wait", c_WAIT, 1, 8'h00, 0);
        cyc("s2_w1exe", c_EXECUTE, 1, 8'h00, 0);
        cyc("s2_w1upd", c_UPDATE, 1, 8'h00, 0);
        decoded_ret = 1;
        cyc("s2_done", c_DONE, 1, 8'h00, 1);
`endif
        decoded_ret = 0; start = 1;
        cyc("s2_hold_done", c_DONE, 1'(dut.sel_q), current_pc, 1);
        start = 0;

        // Reset mid-operation, reset beats start, empty launch
        reset = 1;
        cyc("s3_rst", c_IDLE, 0, 8'h00, 0);
        reset = 0; warp_enable = 2'b01; start = 1;
        cyc("s3_start", c_FETCH, 0, 8'h00, 0);
        start = 0; fetcher_done = 1;
        cyc("s3_dec", c_DECODE, 0, 8'h00, 0);
        fetcher_done = 0;
        cyc("s3_req", c_REQUEST, 0, 8'h00, 0);
        cyc("s3_wait", c_WAIT, 0, 8'h00, 0);
        cyc("s3_exe", c_EXECUTE, 0, 8'h00, 0);
        next_pc = 8'h55;
        cyc("s3_upd", c_UPDATE, 0, 8'h00, 0);
        cyc("s3_pc", c_FETCH, 0, 8'h55, 0);
        fetcher_done = 1;
        cyc("s3_dec2", c_DECODE, 0, 8'h55, 0);
        fetcher_done = 0;
        cyc("s3_req2", c_REQUEST, 0, 8'h55, 0);
        mem_pending = 2'b01;
        cyc("s3_wait2", c_WAIT, 0, 8'h55, 0);
        cyc("s3_wait_hold", c_WAIT, 0, 8'h55, 0);
        reset = 1; start = 1;
        cyc("s3_rst_wait", c_IDLE, 0, 8'h00, 0);
        cyc("s3_rst_start", c_IDLE, 0, 8'h00, 0);
        reset = 0; mem_pending = 2'b00; warp_enable = 2'b00;
        cyc("s3_empty", c_DONE, 0, 8'h00, 1);
        start = 0;
        cyc("s3_empty_hold", c_DONE, 0, 8'h00, 1);

        // Lowest live warp selection
        reset = 1;
        cyc("s4_rst", c_IDLE, 0, 8'h00, 0);
        reset = 0; warp_enable = 2'b10; start = 1;
        cyc("s4_low", c_FETCH, 1, 8'h00, 0);
        start = 0;

        // RET switch resumes a warp from its saved context
        reset = 1;
        cyc("s5_rst", c_IDLE, 0, 8'h00, 0);
        reset = 0; warp_enable = 2'b11; saved_state[0] = c_IDLE;
        saved_state[1] = c_DECODE; saved_pc[1] = 8'h33; start = 1;
        cyc("s5_start", c_FETCH, 0, 8'h00, 0);
        start = 0; fetcher_done = 1;
        cyc("s5_dec", c_DECODE, 0, 8'h00, 0);
        fetcher_done = 0;
        cyc("s5_req", c_REQUEST, 0, 8'h00, 0);
        cyc("s5_wait", c_WAIT, 0, 8'h00, 0);
        cyc("s5_exe", c_EXECUTE, 0, 8'h00, 0);
        cyc("s5_upd", c_UPDATE, 0, 8'h00, 0);
        decoded_ret = 1;
        cyc("s5_resume", c_DECODE, 1, 8'h33, 0);
        decoded_ret = 0;
        cyc("s5_req1", c_REQUEST, 1, 8'h33, 0);
        cyc("s5_wait1", c_WAIT, 1, 8'h33, 0);
        cyc("s5_exe1", c_EXECUTE, 1, 8'h33, 0);
        cyc("s5_upd1", c_UPDATE, 1, 8'h33, 0);
        decoded_ret = 1;
        cyc("s5_done", c_DONE, 1, 8'h33, 1);
        decoded_ret = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
